// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the iterative divider.
package div_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Quotient bits are filled with this value on a divide by zero.
    localparam logic DBZ_FILL = 1'b1;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division iteration.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] shifted, trial;

    // W+1 bits are enough: the shifted remainder stays below 2*dvs.
    always_comb begin
        shifted  = {rem, bit_in};
        trial    = shifted - {1'b0, dvs};
        q_bit    = ~trial[W];
        rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU, one quotient bit per cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_w(W);

    div_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem, dvd, dvs_mag, raw_dvd, rem_next, q_fin;
    logic          q_neg, r_neg, dbz, q_bit, last, accept;

    div_step #(.W(W)) u_step (
        .rem      (rem),
        .bit_in   (dvd[W-1]),
        .dvs      (dvs_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign last   = cnt == CW'(W - 1);
    assign accept = start && state != DIV_CALC;
    assign q_fin  = {dvd[W-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= DIV_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == DIV_CALC) ? (last ? DIV_DONE : DIV_CALC)
                                        : (start ? DIV_CALC : DIV_IDLE);
    end

    always_comb begin
        busy = state == DIV_CALC;
        done = state == DIV_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dvs_mag     <= '0;
            raw_dvd     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            dvd     <= is_signed && dividend[W-1] ? -dividend : dividend;
            dvs_mag <= is_signed && divisor[W-1] ? -divisor : divisor;
            raw_dvd <= dividend;
            q_neg   <= is_signed && (dividend[W-1] ^ divisor[W-1]);
            r_neg   <= is_signed && dividend[W-1];
            dbz     <= divisor == '0;
        end else if (state == DIV_CALC) begin
            cnt <= cnt + CW'(1);
            rem <= rem_next;
            dvd <= q_fin;
            // Negating a zero remainder yields zero, so no special case is needed.
            if (last) begin
                quotient    <= dbz ? {W{DBZ_FILL}} : (q_neg ? -q_fin : q_fin);
                remainder   <= dbz ? raw_dvd : (r_neg ? -rem_next : rem_next);
                div_by_zero <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors checked against an arithmetic reference model.
module tb_div_unit;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient, remainder;

    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 0;
    int   m_left = 0;
    bit   m_done = 0;
    res_t p = '0, e = '0, pl = '0, el = '0, lit = '0;

    div_unit #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        res_t   r;
        longint sa, sb, sq, sr;
        if (b == 0) begin
            r.q = '1;
            r.r = a;
            r.z = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sq  = sa / sb;
            sr  = sa % sb;
            r.q = sq[DW-1:0];
            r.r = sr[DW-1:0];
            r.z = 1'b0;
        end else begin
            r.q = a / b;
            r.r = a % b;
            r.z = 1'b0;
        end
        return r;
    endfunction

    // Reference timing: an accepted start completes DW cycles later; results then hold.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 0;
            e      <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                e  <= p;
                el <= pl;
            end
        end else begin
            m_done <= 0;
            if (start) begin
                m_left <= DW;
                p      <= model(is_signed, dividend, divisor);
                pl     <= lit;
            end
        end
    end

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", DW'(busy), DW'(m_left != 0));
            chk("done", DW'(done), DW'(m_done));
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", DW'(div_by_zero), DW'(e.z));
            if (m_done) begin
                chk("lit_quotient", quotient, el.q);
                chk("lit_remainder", remainder, el.r);
                chk("lit_dbz", DW'(div_by_zero), DW'(el.z));
                chk("model_quotient", e.q, el.q);
                chk("model_remainder", e.r, el.r);
            end
        end
    end

    // Issues one operation and returns during its done cycle; poke re-asserts start mid-CALC.
    task automatic op(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] lq, input logic [DW-1:0] lr, input bit lz,
                      input bit now = 0, input int poke = 0);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        lit       = '{lq, lr, lz};
        for (int i = 1; i <= DW; i++) begin
            @(posedge clk);
            #1;
            start     = (i == poke);
            is_signed = ~s;
            dividend  = $urandom;
            divisor   = $urandom;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1;
        op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        repeat (4) @(posedge clk);
        op(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        op(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);
        op(0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        op(1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1);
        op(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        op(1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 32'd0, 0);
        op(0, 32'd1000, 32'd10, 32'd100, 32'd0, 0, 0, 5);
        op(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
        op(1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd4;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        op(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
